shift_ctrl: RTL and testbench
=============================

Name: shift_ctrl

Overview:
Sequencer and arbiter that shares the single 16-bit barrel shifter between two requesters (e.g. the execute-stage ALU and a multi-cycle helper unit). It performs round-robin arbitration, captures the operands and drives the shifter for one or two passes. It returns a registered result through a valid/ready response channel. With the optional feature it builds rotate-right from two shifter passes.

Parameters:
- W, 16, data width; fixed by the shifter, must not be overridden.
- AMT_W, 4, shift-amount width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising clk edge.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_data  in  16  operand 0.
- req0_amt  in  4  shift amount 0.
- req0_op  in  2  operation 0: 00=SLL, 01=SRA, 10=ROR, 11=reserved.
- req1_valid, req1_ready, req1_data, req1_amt, req1_op: same set for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  requester index that owns the result.
- rsp_data  out  16  result.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- States: IDLE, PASS1, PASS2, RESP.
- Reset values: state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, last_grant=1 (requester 0 wins first), all operand registers=0. reqX_ready is combinational and is 0 during reset.
- IDLE: the grant goes to the single valid requester. If both are valid, the grant goes to the requester other than last_grant. reqX_ready=1 only for the granted requester, only in IDLE. On that cycle: capture data/amt/op/id, update last_grant, go to PASS1. With no valid request, stay in IDLE.
- PASS1, SLL or SRA: drive the shifter with the captured data/amt and Mode=op[0]. Register the output into rsp_data and go to RESP.
- PASS1, ROR: drive SLL by (16-amt) mod 16, register the result into tmp, go to PASS2.
- PASS2 (ROR only): drive SRA by amt. rsp_data = (sra_out & (16'hFFFF >> amt)) | tmp. Go to RESP.
- amt=0 ROR returns data unchanged.
- RESP: rsp_valid=1. rsp_data and rsp_id stay stable until rsp_ready=1. On rsp_valid && rsp_ready, clear rsp_valid and go to IDLE.
- No request is accepted in RESP, so the earliest next accept is the cycle after the response handshake.
- Latency, accept edge to rsp_valid: SLL/SRA 2 cycles, ROR 3 cycles.
- Reserved op 11: pass-through; shift amount forced to 0, result = data, 2-cycle latency.
- Request inputs are ignored outside IDLE. A requester must hold valid and its fields stable until ready.
- rst_n low in any state returns to the reset values on that edge. An in-flight operation is discarded and no response is produced.

Optional Feature:
- Macro SHIFT_CTRL_ROR_EN.
- Defined: op 10 runs as ROR via PASS1 and PASS2 as described above.
- Undefined: the PASS2 state and the tmp register are not built. Op 10 is treated like the reserved op 11 (pass-through, 2-cycle latency).

Decomposition:
- Package shift_ctrl_pkg holds: opcode constants (OP_SLL, OP_SRA, OP_ROR, OP_RSVD); the state encoding (IDLE/PASS1/PASS2/RESP); the W and AMT_W constants.
- One sub-module instance: the existing Shifter datapath (ports Shift_Out, Shift_In, Shift_Val, Mode), driven from the captured operand mux.
- Arbitration stays inline; no separate arbiter module.

Test Plan:
- req0 SLL, data 0x0001, amt 4, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_data=0x0010, rsp_id=0.
- req1 SRA, data 0x8000, amt 3 -> rsp_data=0xF000, rsp_id=1.
- Both valid in the first cycle after reset (req0 SLL 0x00FF amt 8; req1 SRA 0x7F00 amt 8) -> req0 granted first (0xFF00), then req1 (0x007F). Repeated simultaneous requests alternate 0,1,0,1.
- ROR with SHIFT_CTRL_ROR_EN, data 0x0001 amt 1 -> 0x8000 after 3 cycles. Data 0x1234 amt 4 -> 0x4123. amt 0 -> 0x1234.
- ROR without the macro, data 0x1234 amt 4 -> 0x1234 after 2 cycles.
- rsp_ready held low for 5 cycles -> rsp_valid, rsp_data and rsp_id stable, both req_ready stay 0. rst_n=0 during ROR PASS2 -> next cycle state IDLE, rsp_valid=0, and no response ever appears for that operation.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared constants and types for the shift_ctrl sequencer.
// Holds the datapath widths, the opcode encoding and the FSM state encoding.
package shift_ctrl_pkg;

  localparam int W     = 16;
  localparam int AMT_W = 4;

  typedef logic [W-1:0]     data_t;
  typedef logic [AMT_W-1:0] amt_t;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRA  = 2'b01,
    OP_ROR  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PASS1 = 2'b01,
    PASS2 = 2'b10,
    RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/shift_ctrl_shifter.sv
// Shifter: the shared 16-bit barrel shifter datapath.
// Mode 0 shifts left logically, Mode 1 shifts right arithmetically.
module Shifter
  import shift_ctrl_pkg::*;
(
  output logic [W-1:0]     Shift_Out,
  input  logic [W-1:0]     Shift_In,
  input  logic [AMT_W-1:0] Shift_Val,
  input  logic             Mode
);

  // Purely combinational shift; sign bit is replicated on right shifts.
  always_comb begin
    if (Mode) begin
      Shift_Out = W'($signed(Shift_In) >>> Shift_Val);
    end else begin
      Shift_Out = Shift_In << Shift_Val;
    end
  end

endmodule

// File: rtl/shift_ctrl.sv
// shift_ctrl: round-robin sequencer that shares one barrel shifter between
// two requesters and returns a registered result over a valid/ready channel.
// Optional feature macro SHIFT_CTRL_ROR_EN: when defined, op ROR is built from
// a left-shift pass plus a masked arithmetic right-shift pass. When undefined,
// the second pass and its holding register are absent and ROR behaves like the
// reserved opcode (pass-through).
module shift_ctrl
  import shift_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [W-1:0]     rsp_data,
  output logic             busy
);

  localparam amt_t AMT_ZERO = '0;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;
  data_t  data_q, data_d;
  amt_t   amt_q, amt_d;
  op_e    op_q, op_d;
  logic   id_q, id_d;
  logic   rsp_valid_q, rsp_valid_d;
  data_t  rsp_data_q, rsp_data_d;
`ifdef SHIFT_CTRL_ROR_EN
  data_t  tmp_q, tmp_d;
`endif

  logic   grant;
  amt_t   shift_val;
  logic   shift_mode;
  data_t  shift_out;

  Shifter u_shifter (
    .Shift_Out (shift_out),
    .Shift_In  (data_q),
    .Shift_Val (shift_val),
    .Mode      (shift_mode)
  );

  // Next-state, arbitration, shifter drive and result capture decisions.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    amt_d        = amt_q;
    op_d         = op_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
`ifdef SHIFT_CTRL_ROR_EN
    tmp_d        = tmp_q;
`endif
    grant        = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    shift_val    = AMT_ZERO;
    shift_mode   = 1'b0;

    case (state_q)
      IDLE: begin
        if (rst_n && (req0_valid || req1_valid)) begin
          if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
          end else begin
            grant = req1_valid;
          end
          if (grant) begin
            req1_ready = 1'b1;
            data_d     = req1_data;
            amt_d      = req1_amt;
            op_d       = op_e'(req1_op);
          end else begin
            req0_ready = 1'b1;
            data_d     = req0_data;
            amt_d      = req0_amt;
            op_d       = op_e'(req0_op);
          end
          id_d         = grant;
          last_grant_d = grant;
          state_d      = PASS1;
        end
      end

      PASS1: begin
        if (op_q == OP_SLL || op_q == OP_SRA) begin
          shift_val  = amt_q;
          shift_mode = (op_q == OP_SRA);
        end
`ifdef SHIFT_CTRL_ROR_EN
        if (op_q == OP_ROR) begin
          shift_val  = AMT_ZERO - amt_q;
          shift_mode = 1'b0;
          tmp_d      = shift_out;
          state_d    = PASS2;
        end else begin
          rsp_data_d  = shift_out;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
`else
        rsp_data_d  = shift_out;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
`endif
      end

`ifdef SHIFT_CTRL_ROR_EN
      PASS2: begin
        shift_val   = amt_q;
        shift_mode  = 1'b1;
        rsp_data_d  = (shift_out & ({W{1'b1}} >> amt_q)) | tmp_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
`endif

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset discards any in-flight work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      data_q       <= '0;
      amt_q        <= '0;
      op_q         <= OP_SLL;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
`ifdef SHIFT_CTRL_ROR_EN
      tmp_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      amt_q        <= amt_d;
      op_q         <= op_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
`ifdef SHIFT_CTRL_ROR_EN
      tmp_q        <= tmp_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_ctrl.sv
// tb_shift_ctrl: directed bench for shift_ctrl with a scoreboard queue.
// Expected results are pushed when a request is accepted; a monitor pops and
// compares on every response handshake, including accept-to-valid latency.
module tb_shift_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [15:0] req0_data;
  logic [3:0]  req0_amt;
  logic [1:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [15:0] req1_data;
  logic [3:0]  req1_amt;
  logic [1:0]  req1_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic        busy;

  typedef struct {
    logic        id;
    logic [15:0] data;
    int          accCyc;
    int          lat;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

`ifdef SHIFT_CTRL_ROR_EN
  localparam int RORLAT = 3;
`else
  localparam int RORLAT = 2;
`endif

  shift_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one or both requesters and pushes expected results on acceptance.
  task automatic applyStimulus(
    input bit v0, input logic [15:0] d0, input logic [3:0] a0, input logic [1:0] o0,
    input logic [15:0] e0, input int l0,
    input bit v1, input logic [15:0] d1, input logic [3:0] a1, input logic [1:0] o1,
    input logic [15:0] e1, input int l1,
    input int firstWin);
    bit pend0, pend1, got0, got1;
    int guard;
    pend0 = v0;
    pend1 = v1;
    req0_valid = v0; req0_data = d0; req0_amt = a0; req0_op = o0;
    req1_valid = v1; req1_data = d1; req1_amt = a1; req1_op = o1;
    guard = 0;
    while ((pend0 || pend1) && guard < 100) begin
      @(negedge clk);
      got0 = req0_ready && pend0;
      got1 = req1_ready && pend1;
      if ((got0 || got1) && pend0 && pend1 && firstWin >= 0)
        checkOutput("first_grant", {31'd0, req1_ready}, firstWin);
      if (got0) sbQ.push_back('{id: 1'b0, data: e0, accCyc: cyc, lat: l0});
      if (got1) sbQ.push_back('{id: 1'b1, data: e1, accCyc: cyc, lat: l1});
      @(posedge clk);
      #1;
      if (got0) begin req0_valid = 1'b0; pend0 = 1'b0; end
      if (got1) begin req1_valid = 1'b0; pend1 = 1'b0; end
      guard++;
    end
    if (pend0 || pend1) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: pending0=%0d pending1=%0d expected both accepted", pend0, pend1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while (sbQ.size() != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    checkOutput("drain", sbQ.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every handshake against the head of the scoreboard.
  initial begin
    bit   prevValid;
    int   riseCyc;
    exp_t e;
    prevValid = 1'b0;
    riseCyc = 0;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && !prevValid) riseCyc = cyc;
      prevValid = rst_n && rsp_valid;
      if (rst_n && rsp_valid && rsp_ready) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rsp: got id %0d data %h expected no response", rsp_id, rsp_data);
        end else begin
          e = sbQ.pop_front();
          checkOutput("rsp_data", rsp_data, e.data);
          checkOutput("rsp_id", rsp_id, e.id);
          checkOutput("latency", riseCyc - e.accCyc, e.lat);
        end
      end
    end
  end

  // Directed test sequence.
  initial begin
    int seen;
    int cnt;
    int guard;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 16'h1111; req0_amt = 4'd1; req0_op = 2'b00;
    req1_valid = 1'b1; req1_data = 16'h2222; req1_amt = 4'd1; req1_op = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_data", rsp_data, 16'h0000);
    checkOutput("reset_rsp_id", rsp_id, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_req0_ready", req0_ready, 0);
    checkOutput("reset_req1_ready", req1_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    applyStimulus(1, 16'h00FF, 4'd8, 2'b00, 16'hFF00, 2,
                  1, 16'h7F00, 4'd8, 2'b01, 16'h007F, 2, 0);
    waitDrain();
    applyStimulus(1, 16'h0003, 4'd1, 2'b00, 16'h0006, 2,
                  1, 16'hFFF0, 4'd2, 2'b01, 16'hFFFC, 2, 0);
    waitDrain();

    applyStimulus(1, 16'h0001, 4'd4, 2'b00, 16'h0010, 2,
                  0, 16'h0000, 4'd0, 2'b00, 16'h0000, 2, -1);
    waitDrain();
    applyStimulus(0, 16'h0000, 4'd0, 2'b00, 16'h0000, 2,
                  1, 16'h8000, 4'd3, 2'b01, 16'hF000, 2, -1);
    waitDrain();

`ifdef SHIFT_CTRL_ROR_EN
    applyStimulus(1, 16'h0001, 4'd1, 2'b10, 16'h8000, RORLAT,
                  0, 16'h0000, 4'd0, 2'b00, 16'h0000, 2, -1);
    waitDrain();
    applyStimulus(1, 16'h1234, 4'd4, 2'b10, 16'h4123, RORLAT,
                  0, 16'h0000, 4'd0, 2'b00, 16'h0000, 2, -1);
    waitDrain();
    applyStimulus(0, 16'h0000, 4'd0, 2'b00, 16'h0000, 2,
                  1, 16'h1234, 4'd0, 2'b10, 16'h1234, RORLAT, -1);
    waitDrain();
    applyStimulus(1, 16'h8001, 4'd4, 2'b10, 16'h1800, RORLAT,
                  0, 16'h0000, 4'd0, 2'b00, 16'h0000, 2, -1);
    waitDrain();
`else
    applyStimulus(1, 16'h1234, 4'd4, 2'b10, 16'h1234, RORLAT,
                  0, 16'h0000, 4'd0, 2'b00, 16'h0000, 2, -1);
    waitDrain();
    applyStimulus(0, 16'h0000, 4'd0, 2'b00, 16'h0000, 2,
                  1, 16'h8001, 4'd4, 2'b10, 16'h8001, RORLAT, -1);
    waitDrain();
`endif

    applyStimulus(1, 16'hABCD, 4'd5, 2'b11, 16'hABCD, 2,
                  0, 16'h0000, 4'd0, 2'b00, 16'h0000, 2, -1);
    waitDrain();

    rsp_ready = 1'b0;
    applyStimulus(0, 16'h0000, 4'd0, 2'b00, 16'h0000, 2,
                  1, 16'h0F0F, 4'd4, 2'b00, 16'hF0F0, 2, -1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1;
        break;
      end
    end
    checkOutput("stall_valid_seen", seen, 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_data = 16'h5555; req0_amt = 4'd2; req0_op = 2'b00;
    req1_valid = 1'b1; req1_data = 16'h6666; req1_amt = 4'd2; req1_op = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_rsp_valid", rsp_valid, 1);
      checkOutput("stall_rsp_data", rsp_data, 16'hF0F0);
      checkOutput("stall_rsp_id", rsp_id, 1);
      checkOutput("stall_req0_ready", req0_ready, 0);
      checkOutput("stall_req1_ready", req1_ready, 0);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    waitDrain();

    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 16'h1234; req0_amt = 4'd4; req0_op = 2'b10;
    seen = 0;
    guard = 0;
    while (!seen && guard < 20) begin
      @(negedge clk);
      if (req0_ready) seen = 1;
      guard++;
    end
    checkOutput("abort_accepted", seen, 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_busy_inflight", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_rsp_valid", rsp_valid, 0);
    checkOutput("abort_rsp_data", rsp_data, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    checkOutput("abort_no_rsp", cnt, 0);
    checkOutput("scoreboard_empty", sbQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
